usr_shift_seq: RTL

//  Parametrised universal shift register with a built-in multi-step shift sequencer.

---
 rtl/usr_pkg.sv | 13 +
 rtl/usr_step.sv | 53 +++++
 rtl/usr_shift_seq.sv | 102 ++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Mode encodings shared by the universal shift register and its step logic.
package usr_pkg;

  localparam logic [2:0] USR_HOLD = 3'b000;
  localparam logic [2:0] USR_SHR  = 3'b001;
  localparam logic [2:0] USR_SHL  = 3'b010;
  localparam logic [2:0] USR_LOAD = 3'b011;
  localparam logic [2:0] USR_ROR  = 3'b100;
  localparam logic [2:0] USR_ROL  = 3'b101;
  localparam logic [2:0] USR_ASR  = 3'b110;
  localparam logic [2:0] USR_RSVD = 3'b111;

endpackage

// File: rtl/usr_step.sv
// Combinational next-value logic for one hold/shift/rotate/load step,
// shared by the single-step and sequenced paths.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [2:0]       i_mode,
  input  logic             i_msb_in,
  input  logic             i_lsb_in,
  input  logic [WIDTH-1:0] i_load,
  output logic [WIDTH-1:0] o_a_nxt,
  output logic             o_out_bit,
  output logic             o_shifting
);

  always_comb begin
    o_a_nxt    = i_a;
    o_out_bit  = 1'b0;
    o_shifting = 1'b0;
    case (i_mode)
      USR_SHR: begin
        o_a_nxt    = {i_msb_in, i_a[WIDTH-1:1]};
        o_out_bit  = i_a[0];
        o_shifting = 1'b1;
      end
      USR_SHL: begin
        o_a_nxt    = {i_a[WIDTH-2:0], i_lsb_in};
        o_out_bit  = i_a[WIDTH-1];
        o_shifting = 1'b1;
      end
      USR_LOAD: o_a_nxt = i_load;
      USR_ROR: begin
        o_a_nxt    = {i_a[0], i_a[WIDTH-1:1]};
        o_out_bit  = i_a[0];
        o_shifting = 1'b1;
      end
      USR_ROL: begin
        o_a_nxt    = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
        o_out_bit  = i_a[WIDTH-1];
        o_shifting = 1'b1;
      end
      USR_ASR: begin
        o_a_nxt    = {i_a[WIDTH-1], i_a[WIDTH-1:1]};
        o_out_bit  = i_a[0];
        o_shifting = 1'b1;
      end
      default: o_a_nxt = i_a;  // hold and reserved
    endcase
  end

endmodule

// File: rtl/usr_shift_seq.sv
// Universal shift register with a multi-step shift sequencer (start/busy/done).
// Optional serial-out flop enabled by defining USR_SOUT_EN.
module usr_shift_seq
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       sel,
  input  logic             msb_in,
  input  logic             lsb_in,
  input  logic [WIDTH-1:0] I,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] A,
  output logic             busy,
`ifdef USR_SOUT_EN
  output logic             sout,
`endif
  output logic             done
);

  localparam logic [CNT_W-1:0] REM_LAST = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_a;
  logic [2:0]       r_mode;
  logic [CNT_W-1:0] r_rem;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_mode;
  logic [WIDTH-1:0] w_a_nxt;
  logic             w_out_bit;
  logic             w_shifting;

  // While busy the latched mode drives the step; otherwise sel is applied live.
  assign w_mode = r_busy ? r_mode : sel;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .i_a        (r_a),
    .i_mode     (w_mode),
    .i_msb_in   (msb_in),
    .i_lsb_in   (lsb_in),
    .i_load     (I),
    .o_a_nxt    (w_a_nxt),
    .o_out_bit  (w_out_bit),
    .o_shifting (w_shifting)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_mode <= USR_HOLD;
      r_rem  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_a   <= w_a_nxt;
        r_rem <= r_rem - 1'b1;
        if (r_rem == REM_LAST) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (start) begin
        // Accept edge: A is left untouched, the first step happens next edge.
        r_mode <= sel;
        r_rem  <= cnt;
        if (cnt != '0) r_busy <= 1'b1;
        else           r_done <= 1'b1;
      end else begin
        r_a <= w_a_nxt;
      end
    end
  end

`ifdef USR_SOUT_EN
  logic r_sout;

  // Steps that apply A also capture the departing bit when they shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sout <= 1'b0;
    end else if ((r_busy || !start) && w_shifting) begin
      r_sout <= w_out_bit;
    end
  end

  assign sout = r_sout;
`else
  logic w_unused_sout;
  assign w_unused_sout = w_out_bit ^ w_shifting;
`endif

  assign A    = r_a;
  assign busy = r_busy;
  assign done = r_done;

endmodule
